if_fetch_queue: RTL and testbench

- Sits between the Program_Counter register and the decode stage.
- Accepts fetch addresses from the PC and issues them to instruction memory over a req/gnt request channel.
- Pairs each returning rvalid/rdata response with the PC that requested it, and buffers {pc, instr} pairs in a DEPTH-entry queue.
- Presents that queue to decode with a valid/ready handshake. A flush (taken branch/jump redirect) empties the queue and discards in-flight responses.

---
 rtl/if_fetch_queue_if.sv | 42 ++++
 rtl/if_fetch_queue.sv | 165 ++++++++++++++++
 tb/tb_if_fetch_queue.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/if_fetch_queue_if.sv
`default_nettype none
// ============================================================================
// Module      : if_fetch_queue_if
// Description : Bundles the fetch-queue signals: PC request, instruction
//               memory req/gnt/rvalid channel, redirect flush, decode
//               valid/ready channel and the sticky error flag.
//               The fetch queue connects through the slave modport. The
//               surrounding pipeline (PC, memory, decode) uses the master
//               modport.
// Revision    : 1.0 - initial release
// ============================================================================
interface if_fetch_queue_if #(
    parameter int XLEN = 32
);
    logic [XLEN-1:0] pc_in;
    logic            pc_valid;
    logic            pc_ready;
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_gnt;
    logic            imem_rvalid;
    logic [XLEN-1:0] imem_rdata;
    logic            flush;
    logic            id_valid;
    logic            id_ready;
    logic [XLEN-1:0] id_pc;
    logic [XLEN-1:0] id_instr;
    logic            err;

    // Fetch-queue side
    modport slave (
        input  pc_in, pc_valid, imem_gnt, imem_rvalid, imem_rdata, flush, id_ready,
        output pc_ready, imem_req, imem_addr, id_valid, id_pc, id_instr, err
    );

    // Pipeline / memory / decode side
    modport master (
        output pc_in, pc_valid, imem_gnt, imem_rvalid, imem_rdata, flush, id_ready,
        input  pc_ready, imem_req, imem_addr, id_valid, id_pc, id_instr, err
    );
endinterface
`default_nettype wire

// File: rtl/if_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : if_fetch_queue
// Description : Instruction fetch queue between the PC register and decode.
//               Issues fetch addresses to instruction memory, pairs each
//               in-order response with the PC that requested it, and buffers
//               {pc, instr} pairs for decode. A flush empties the queue and
//               discards responses still in flight.
// Revision    : 1.0 - initial release
// ============================================================================
module if_fetch_queue #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32
) (
    input  logic            clk,
    input  logic            reset,   // synchronous, active-low
    if_fetch_queue_if.slave bus
);

    localparam int c_idx_w = $clog2(DEPTH);
    localparam int c_cnt_w = c_idx_w + 1;
    // Sum of three counters each bounded by DEPTH; two guard bits avoid wrap.
    localparam int c_sum_w = c_cnt_w + 2;
    localparam logic [c_sum_w-1:0] c_depth_s = c_sum_w'(DEPTH);
    localparam logic [c_cnt_w-1:0] c_cnt_zero = '0;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    // PCs of granted requests that are still waiting for their response
    logic [XLEN-1:0]    r_pcq_mem [DEPTH];
    logic [c_cnt_w-1:0] r_pcq_wr;
    logic [c_cnt_w-1:0] r_pcq_rd;

    // {pc, instr} entries waiting for decode
    logic [XLEN-1:0]    r_iq_pc    [DEPTH];
    logic [XLEN-1:0]    r_iq_instr [DEPTH];
    logic [c_cnt_w-1:0] r_iq_wr;
    logic [c_cnt_w-1:0] r_iq_rd;

    // Responses belonging to flushed requests that have yet to arrive
    logic [c_cnt_w-1:0] r_drop_cnt;
    logic               r_err;

    // ------------------------------------------------------------------------
    // Occupancy and credit
    // ------------------------------------------------------------------------
    logic [c_cnt_w-1:0] w_outstanding;
    logic [c_cnt_w-1:0] w_iq_cnt;
    logic [c_sum_w-1:0] w_used;
    logic               w_has_credit;

    assign w_outstanding = r_pcq_wr - r_pcq_rd;
    assign w_iq_cnt      = r_iq_wr - r_iq_rd;
    assign w_used        = c_sum_w'(w_iq_cnt) + c_sum_w'(w_outstanding) + c_sum_w'(r_drop_cnt);
    // Every slot that is queued, in flight or owed to a flushed request
    // consumes credit, so an accepted response always finds room in iq.
    assign w_has_credit  = (w_used < c_depth_s);

    // ------------------------------------------------------------------------
    // Request channel
    // ------------------------------------------------------------------------
    logic w_req;
    logic w_grant;

    // Outputs are forced low while reset is held so nothing escapes before
    // the state has been initialised.
    assign w_req         = reset & bus.pc_valid & w_has_credit & ~bus.flush;
    assign w_grant       = w_req & bus.imem_gnt;
    assign bus.imem_req  = w_req;
    assign bus.pc_ready  = w_grant;
    assign bus.imem_addr = {bus.pc_in[XLEN-1:2], 2'b00};

    // ------------------------------------------------------------------------
    // Response classification
    // ------------------------------------------------------------------------
    logic w_drop_pending;
    logic w_out_pending;
    logic w_rsp_drop;
    logic w_rsp_accept;
    logic w_rsp_unsol;

    assign w_drop_pending = (r_drop_cnt != c_cnt_zero);
    assign w_out_pending  = (w_outstanding != c_cnt_zero);
    // Owed to a flushed request: discard the data
    assign w_rsp_drop     = bus.imem_rvalid & w_drop_pending;
    // Belongs to the oldest live request: pair it with its PC
    assign w_rsp_accept   = bus.imem_rvalid & ~w_drop_pending & w_out_pending & ~bus.flush;
    // Nothing to match against: protocol error
    assign w_rsp_unsol    = bus.imem_rvalid & ~w_drop_pending & ~w_out_pending;

    // Drop count after a flush: everything still in flight becomes owed,
    // minus the response (if any, and if it was expected) arriving right now.
    logic               w_flush_rsp;
    logic [c_cnt_w-1:0] w_flush_drop;

    assign w_flush_rsp  = bus.imem_rvalid & (w_drop_pending | w_out_pending);
    assign w_flush_drop = r_drop_cnt + w_outstanding - c_cnt_w'(w_flush_rsp);

    // ------------------------------------------------------------------------
    // Decode side
    // ------------------------------------------------------------------------
    logic w_id_valid;
    logic w_id_pop;

    assign w_id_valid   = reset & (w_iq_cnt != c_cnt_zero) & ~bus.flush;
    assign w_id_pop     = w_id_valid & bus.id_ready;
    assign bus.id_valid = w_id_valid;
    assign bus.id_pc    = r_iq_pc[r_iq_rd[c_idx_w-1:0]];
    assign bus.id_instr = r_iq_instr[r_iq_rd[c_idx_w-1:0]];
    assign bus.err      = r_err;

    // ------------------------------------------------------------------------
    // Sequential logic
    // ------------------------------------------------------------------------
    // Pointer, drop-count and error bookkeeping; flush outranks everything
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_pcq_wr   <= '0;
            r_pcq_rd   <= '0;
            r_iq_wr    <= '0;
            r_iq_rd    <= '0;
            r_drop_cnt <= '0;
            r_err      <= 1'b0;
        end else begin
            if (w_rsp_unsol) begin
                r_err <= 1'b1;
            end
            if (bus.flush) begin
                r_pcq_wr   <= '0;
                r_pcq_rd   <= '0;
                r_iq_wr    <= '0;
                r_iq_rd    <= '0;
                r_drop_cnt <= w_flush_drop;
            end else begin
                if (w_grant) begin
                    r_pcq_wr <= r_pcq_wr + 1'b1;
                end
                if (w_rsp_drop) begin
                    r_drop_cnt <= r_drop_cnt - 1'b1;
                end
                if (w_rsp_accept) begin
                    r_pcq_rd <= r_pcq_rd + 1'b1;
                    r_iq_wr  <= r_iq_wr + 1'b1;
                end
                if (w_id_pop) begin
                    r_iq_rd <= r_iq_rd + 1'b1;
                end
            end
        end
    end

    // Storage arrays: capture granted PCs and matched {pc, instr} pairs
    always_ff @(posedge clk) begin
        if (w_grant) begin
            r_pcq_mem[r_pcq_wr[c_idx_w-1:0]] <= bus.pc_in;
        end
        if (w_rsp_accept) begin
            r_iq_pc[r_iq_wr[c_idx_w-1:0]]    <= r_pcq_mem[r_pcq_rd[c_idx_w-1:0]];
            r_iq_instr[r_iq_wr[c_idx_w-1:0]] <= bus.imem_rdata;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_if_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_if_fetch_queue
// Description : Directed self-checking bench for if_fetch_queue (DEPTH=4):
//               reset, streaming, backpressure, flush with and without a
//               coincident response, and unsolicited response error.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_if_fetch_queue;

    logic clk;
    logic reset;
    int   total;
    int   bad;

    if_fetch_queue_if #(.XLEN(32)) bus ();

    if_fetch_queue #(.DEPTH(4), .XLEN(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance to 1ns after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Let combinational outputs respond to freshly driven inputs
    task automatic settle();
        #1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b0;
        bus.pc_in       = 32'h0;
        bus.pc_valid    = 1'b1;
        bus.imem_gnt    = 1'b0;
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = 32'h0;
        bus.flush       = 1'b0;
        bus.id_ready    = 1'b0;

        // ---------------- reset ----------------
        tick();
        check("rst_req", bus.imem_req, 0);
        check("rst_idv", bus.id_valid, 0);
        tick();
        check("rst_req2", bus.imem_req, 0);
        check("rst_pcr", bus.pc_ready, 0);
        check("rst_idv2", bus.id_valid, 0);
        check("rst_err", bus.err, 0);
        reset = 1'b1;
        settle();
        check("first_req", bus.imem_req, 1);
        check("first_addr", bus.imem_addr, 32'h0000_0000);

        // ---------------- streaming ----------------
        bus.imem_gnt = 1'b1;
        bus.id_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            bus.pc_valid    = (i < 4);
            bus.pc_in       = 32'(4 * i);
            bus.imem_rvalid = (i >= 1 && i <= 4);
            bus.imem_rdata  = 32'h13 + 32'(i) - 32'h1;
            settle();
            check("str_idv", bus.id_valid, (i >= 2) ? 1 : 0);
            if (i < 4) check("str_pcr", bus.pc_ready, 1);
            if (i >= 2) begin
                check("str_pc", bus.id_pc, 32'(4 * (i - 2)));
                check("str_ins", bus.id_instr, 32'h13 + 32'(i - 2));
            end
            tick();
        end
        bus.imem_rvalid = 1'b0;
        settle();
        check("str_end_idv", bus.id_valid, 0);
        check("str_err", bus.err, 0);

        // ---------------- backpressure ----------------
        bus.id_ready = 1'b0;
        bus.pc_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.pc_in       = 32'h20 + 32'(4 * i);
            bus.imem_rvalid = (i >= 1);
            bus.imem_rdata  = 32'hA0 + 32'(i) - 32'h1;
            settle();
            check("bp_grant", bus.pc_ready, 1);
            tick();
        end
        // cycle 4: queue 3 + 1 outstanding = full credit
        bus.pc_in       = 32'h30;
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = 32'hA3;
        settle();
        check("bp_full_req", bus.imem_req, 0);
        check("bp_full_pcr", bus.pc_ready, 0);
        tick();
        // cycle 5: iq full, pop head; credit not yet returned
        bus.imem_rvalid = 1'b0;
        bus.id_ready    = 1'b1;
        settle();
        check("bp_pop_req", bus.imem_req, 0);
        check("bp_head_pc", bus.id_pc, 32'h20);
        check("bp_head_ins", bus.id_instr, 32'hA0);
        tick();
        // cycle 6: one credit back, one grant
        bus.id_ready = 1'b0;
        settle();
        check("bp_regrant", bus.pc_ready, 1);
        check("bp_head2_pc", bus.id_pc, 32'h24);
        tick();
        // cycle 7: full again
        bus.pc_in = 32'h34;
        settle();
        check("bp_full2_req", bus.imem_req, 0);
        // drain: response for 0x30 arrives, decode pops 4 entries
        bus.pc_valid    = 1'b0;
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = 32'hA4;
        bus.id_ready    = 1'b1;
        settle();
        check("dr_pc0", bus.id_pc, 32'h24);
        tick();
        bus.imem_rvalid = 1'b0;
        settle();
        check("dr_pc1", bus.id_pc, 32'h28);
        tick();
        check("dr_pc2", bus.id_pc, 32'h2C);
        tick();
        check("dr_pc3", bus.id_pc, 32'h30);
        check("dr_ins3", bus.id_instr, 32'hA4);
        tick();
        check("dr_empty", bus.id_valid, 0);

        // ---------------- flush: 2 outstanding, 1 queued ----------------
        bus.id_ready = 1'b0;
        bus.pc_valid = 1'b1;
        bus.pc_in    = 32'h40;
        tick();
        bus.pc_in       = 32'h44;
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = 32'hB0;
        tick();
        bus.pc_in       = 32'h48;
        bus.imem_rvalid = 1'b0;
        settle();
        check("fl_pre_idv", bus.id_valid, 1);
        check("fl_pre_pc", bus.id_pc, 32'h40);
        tick();
        bus.flush    = 1'b1;
        bus.pc_in    = 32'h4C;
        bus.id_ready = 1'b1;
        settle();
        check("fl_req", bus.imem_req, 0);
        check("fl_idv", bus.id_valid, 0);
        tick();
        bus.flush       = 1'b0;
        bus.id_ready    = 1'b0;
        bus.pc_in       = 32'h100;
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = 32'hDEAD_0001;
        settle();
        check("fl_empty", bus.id_valid, 0);
        check("fl_tgt_pcr", bus.pc_ready, 1);
        check("fl_tgt_addr", bus.imem_addr, 32'h100);
        tick();
        bus.pc_valid   = 1'b0;
        bus.imem_rdata = 32'hDEAD_0002;
        settle();
        check("fl_drop1", bus.id_valid, 0);
        tick();
        bus.imem_rdata = 32'h93;
        settle();
        check("fl_drop2", bus.id_valid, 0);
        tick();
        bus.imem_rvalid = 1'b0;
        settle();
        check("fl_new_idv", bus.id_valid, 1);
        check("fl_new_pc", bus.id_pc, 32'h100);
        check("fl_new_ins", bus.id_instr, 32'h93);
        check("fl_err", bus.err, 0);
        bus.id_ready = 1'b1;
        tick();
        bus.id_ready = 1'b0;
        settle();
        check("fl_done", bus.id_valid, 0);

        // ---------------- flush coincident with rvalid, 3 outstanding ----------------
        bus.pc_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.pc_in = 32'h200 + 32'(4 * i);
            settle();
            check("fc_grant", bus.pc_ready, 1);
            tick();
        end
        bus.flush       = 1'b1;
        bus.pc_valid    = 1'b0;
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = 32'hBAD0;
        settle();
        check("fc_req", bus.imem_req, 0);
        tick();
        bus.flush      = 1'b0;
        bus.pc_valid   = 1'b1;
        bus.pc_in      = 32'h300;
        bus.imem_rdata = 32'hBAD1;
        settle();
        check("fc_tgt_pcr", bus.pc_ready, 1);
        tick();
        bus.pc_valid   = 1'b0;
        bus.imem_rdata = 32'hBAD2;
        settle();
        check("fc_drop1", bus.id_valid, 0);
        tick();
        bus.imem_rdata = 32'h33;
        settle();
        check("fc_drop2", bus.id_valid, 0);
        tick();
        bus.imem_rvalid = 1'b0;
        settle();
        check("fc_new_idv", bus.id_valid, 1);
        check("fc_new_pc", bus.id_pc, 32'h300);
        check("fc_new_ins", bus.id_instr, 32'h33);
        check("fc_err", bus.err, 0);

        // ---------------- unsolicited response ----------------
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = 32'hFFFF;
        tick();
        bus.imem_rvalid = 1'b0;
        settle();
        check("us_err", bus.err, 1);
        check("us_idv", bus.id_valid, 1);
        check("us_pc", bus.id_pc, 32'h300);
        check("us_ins", bus.id_instr, 32'h33);
        bus.id_ready = 1'b1;
        tick();
        bus.id_ready = 1'b0;
        settle();
        check("us_empty", bus.id_valid, 0);
        check("us_sticky", bus.err, 1);

        // ---------------- reset clears err ----------------
        reset        = 1'b0;
        bus.pc_valid = 1'b1;
        settle();
        check("rr_req", bus.imem_req, 0);
        tick();
        check("rr_err", bus.err, 0);
        check("rr_idv", bus.id_valid, 0);
        reset = 1'b1;
        settle();
        check("rr_req_rel", bus.imem_req, 1);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
